// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Multi-port GPR bank with optional write-to-read bypass and a
//            per-register busy scoreboard for issue hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                N_READ   = 2,
  parameter int                N_WRITE  = 1,
  parameter bit                BYPASS   = 1'b1,
  parameter int                SP_INDEX = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000FFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_READ*ADDR_W-1:0]   i_rd_sel,
  output logic [N_READ*DATA_W-1:0]   o_rd_val,
  output logic [N_READ-1:0]          o_rd_busy,
  input  logic [N_WRITE-1:0]         i_wr_en,
  input  logic [N_WRITE*ADDR_W-1:0]  i_wr_sel,
  input  logic [N_WRITE*DATA_W-1:0]  i_wr_val,
  input  logic                       i_res_en,
  input  logic [ADDR_W-1:0]          i_res_sel
);

  localparam int c_DEPTH = 2 ** ADDR_W;
  // Flat reset image: all zero except the stack pointer slot.
  localparam logic [c_DEPTH*DATA_W-1:0] c_INIT =
    {{((c_DEPTH-1)*DATA_W){1'b0}}, SP_RESET} << (SP_INDEX * DATA_W);

  logic [c_DEPTH*DATA_W-1:0] r_regs = c_INIT;
  logic [c_DEPTH-1:0]        r_busy = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= c_INIT;
      r_busy <= '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest port wins a conflict.
      for (int p = 0; p < N_WRITE; p++) begin
        if (i_wr_en[p] && (i_wr_sel[p*ADDR_W +: ADDR_W] != '0)) begin
          r_regs[i_wr_sel[p*ADDR_W +: ADDR_W]*DATA_W +: DATA_W] <= i_wr_val[p*DATA_W +: DATA_W];
          r_busy[i_wr_sel[p*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      // A new reservation supersedes the producer retiring this cycle.
      if (i_res_en && (i_res_sel != '0)) begin
        r_busy[i_res_sel] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] w_sel;
    logic [DATA_W-1:0] w_val;
    logic              w_busy;
    logic              w_hit;

    assign w_sel = i_rd_sel[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_val  = r_regs[w_sel*DATA_W +: DATA_W];
      w_busy = r_busy[w_sel];
      w_hit  = 1'b0;
      if (BYPASS && !rst) begin
        for (int p = 0; p < N_WRITE; p++) begin
          if (i_wr_en[p] && (i_wr_sel[p*ADDR_W +: ADDR_W] == w_sel)) begin
            w_val = i_wr_val[p*DATA_W +: DATA_W];
            w_hit = 1'b1;
          end
        end
      end
      if (w_hit && !(i_res_en && (i_res_sel == w_sel))) begin
        w_busy = 1'b0;
      end
      if (w_sel == '0) begin
        w_val  = '0;
        w_busy = 1'b0;
      end
    end

    assign o_rd_val[i*DATA_W +: DATA_W] = w_val;
    assign o_rd_busy[i]                 = w_busy;
  end : g_rd

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Directed table plus randomized checks of reg_file_mp (bypass and
//            non-bypass builds) against a behavioural register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_sel;
  logic [63:0] rd_val;
  logic [1:0]  rd_busy;
  logic [63:0] rd_val_nb;
  logic [1:0]  rd_busy_nb;
  logic [1:0]  wr_en;
  logic [9:0]  wr_sel;
  logic [63:0] wr_val;
  logic        res_en;
  logic [4:0]  res_sel;

  int errors = 0;
  int checks = 0;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .N_READ(2), .N_WRITE(2), .BYPASS(1'b1),
                .SP_INDEX(29), .SP_RESET(32'h0000FFFF)) dut (
    .clk(clk), .rst(rst), .i_rd_sel(rd_sel), .o_rd_val(rd_val), .o_rd_busy(rd_busy),
    .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_val(wr_val),
    .i_res_en(res_en), .i_res_sel(res_sel)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .N_READ(2), .N_WRITE(1), .BYPASS(1'b0),
                .SP_INDEX(29), .SP_RESET(32'h0000FFFF)) dut_nb (
    .clk(clk), .rst(rst), .i_rd_sel(rd_sel), .o_rd_val(rd_val_nb), .o_rd_busy(rd_busy_nb),
    .i_wr_en(wr_en[0:0]), .i_wr_sel(wr_sel[4:0]), .i_wr_val(wr_val[31:0]),
    .i_res_en(res_en), .i_res_sel(res_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: index 0 = bypass/2-writer DUT, index 1 = no-bypass/1-writer DUT.
  logic [31:0] m_reg  [2][32];
  logic        m_busy [2][32];

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  ws0;
    logic [31:0] wv0;
    logic [4:0]  ws1;
    logic [31:0] wv1;
    logic        re;
    logic [4:0]  rs;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic        eb0;
    logic [31:0] e1;
    logic        eb1;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic r, logic [1:0] we, logic [4:0] ws0, logic [31:0] wv0,
                              logic [4:0] ws1, logic [31:0] wv1, logic re, logic [4:0] rs,
                              logic [4:0] r0, logic [4:0] r1, logic [31:0] e0, logic eb0,
                              logic [31:0] e1, logic eb1);
    vec_t v;
    v.rst = r; v.we = we; v.ws0 = ws0; v.wv0 = wv0; v.ws1 = ws1; v.wv1 = wv1;
    v.re = re; v.rs = rs; v.r0 = r0; v.r1 = r1;
    v.e0 = e0; v.eb0 = eb0; v.e1 = e1; v.eb1 = eb1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[k][r]  = 32'h0;
        m_busy[k][r] = 1'b0;
      end
      m_reg[k][29] = 32'h0000FFFF;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < ((k == 0) ? 2 : 1); p++) begin
          if (wr_en[p] && wr_sel[p*5 +: 5] != 5'd0) begin
            m_reg[k][wr_sel[p*5 +: 5]]  = wr_val[p*32 +: 32];
            m_busy[k][wr_sel[p*5 +: 5]] = 1'b0;
          end
        end
        if (res_en && res_sel != 5'd0) m_busy[k][res_sel] = 1'b1;
      end
    end
  endtask

  function automatic void model_read(input int k, input logic [4:0] s,
                                     output logic [31:0] v, output logic b);
    logic hit;
    v   = m_reg[k][s];
    b   = m_busy[k][s];
    hit = 1'b0;
    if (k == 0 && !rst) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && wr_sel[p*5 +: 5] == s) begin
          v   = wr_val[p*32 +: 32];
          hit = 1'b1;
        end
      end
      if (hit && !(res_en && res_sel == s)) b = 1'b0;
    end
    if (s == 5'd0) begin
      v = 32'h0;
      b = 1'b0;
    end
  endfunction

  task automatic check_models(input string tag);
    logic [31:0] ev;
    logic        eb;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        model_read(k, rd_sel[i*5 +: 5], ev, eb);
        chk($sformatf("%s dut%0d val%0d", tag, k, i),
            (k == 0) ? rd_val[i*32 +: 32] : rd_val_nb[i*32 +: 32], ev);
        chk($sformatf("%s dut%0d busy%0d", tag, k, i),
            {31'd0, (k == 0) ? rd_busy[i] : rd_busy_nb[i]}, {31'd0, eb});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    rst     = v.rst;
    wr_en   = v.we;
    wr_sel  = {v.ws1, v.ws0};
    wr_val  = {v.wv1, v.wv0};
    res_en  = v.re;
    res_sel = v.rs;
    rd_sel  = {v.r1, v.r0};
  endtask

  initial begin
    model_reset();
    tbl[0]  = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 29, 0, 32'hFFFF, 0, 0, 0);
    tbl[1]  = mk(1, 2'd1, 8, 32'hDEADBEEF, 0, 0,     0, 0, 8, 29, 0, 0, 32'hFFFF, 0);
    tbl[2]  = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 0, 8, 0, 0, 0, 0);
    tbl[3]  = mk(0, 2'd1, 8, 32'hDEADBEEF, 0, 0,     0, 0, 8, 29, 32'hDEADBEEF, 0, 32'hFFFF, 0);
    tbl[4]  = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 8, 8, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    tbl[5]  = mk(0, 2'd1, 0, 32'h12345678, 0, 0,     1, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 0, 8, 0, 0, 32'hDEADBEEF, 0);
    tbl[7]  = mk(0, 2'd3, 5, 32'hA,        5, 32'hB, 0, 0, 5, 5, 32'hB, 0, 32'hB, 0);
    tbl[8]  = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 5, 8, 32'hB, 0, 32'hDEADBEEF, 0);
    tbl[9]  = mk(0, 2'd0, 0, 0,            0, 0,     1, 9, 9, 9, 0, 0, 0, 0);
    tbl[10] = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 9, 9, 0, 1, 0, 1);
    tbl[11] = mk(0, 2'd2, 0, 0,            9, 32'h7, 0, 0, 9, 8, 32'h7, 0, 32'hDEADBEEF, 0);
    tbl[12] = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 9, 9, 32'h7, 0, 32'h7, 0);
    tbl[13] = mk(0, 2'd1, 9, 32'h55,       0, 0,     1, 9, 9, 9, 32'h55, 0, 32'h55, 0);
    tbl[14] = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 9, 9, 32'h55, 1, 32'h55, 1);
    tbl[15] = mk(0, 2'd0, 0, 0,            0, 0,     1, 3, 3, 3, 0, 0, 0, 0);
    tbl[16] = mk(0, 2'd1, 3, 32'h5,        0, 0,     1, 4, 3, 4, 32'h5, 0, 0, 0);
    tbl[17] = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 3, 4, 32'h5, 0, 0, 1);
    tbl[18] = mk(1, 2'd1, 6, 32'h66,       0, 0,     1, 7, 6, 4, 0, 0, 0, 1);
    tbl[19] = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 3, 4, 0, 0, 0, 0);
    tbl[20] = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 6, 29, 0, 0, 32'hFFFF, 0);
    tbl[21] = mk(0, 2'd0, 0, 0,            0, 0,     0, 0, 9, 7, 0, 0, 0, 0);

    for (int n = 0; n < 22; n++) begin
      apply(tbl[n]);
      #2;
      chk($sformatf("row%0d val0", n), rd_val[31:0], tbl[n].e0);
      chk($sformatf("row%0d busy0", n), {31'd0, rd_busy[0]}, {31'd0, tbl[n].eb0});
      chk($sformatf("row%0d val1", n), rd_val[63:32], tbl[n].e1);
      chk($sformatf("row%0d busy1", n), {31'd0, rd_busy[1]}, {31'd0, tbl[n].eb1});
      check_models($sformatf("row%0d", n));
      tick();
    end

    // Non-bypass build: old value in the write cycle, new value one cycle later.
    apply(mk(0, 2'd1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 8, 8, 0, 0, 0, 0));
    #2;
    chk("nobyp same-cycle", rd_val_nb[31:0], 32'h0);
    chk("byp same-cycle", rd_val[31:0], 32'hDEADBEEF);
    tick();
    apply(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 8, 8, 0, 0, 0, 0));
    #2;
    chk("nobyp next-cycle", rd_val_nb[31:0], 32'hDEADBEEF);
    tick();

    // Random traffic over a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 31) == 0);
      wr_en   = 2'($urandom_range(0, 3));
      wr_sel  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_val  = {$urandom, $urandom};
      res_en  = ($urandom_range(0, 2) == 0);
      res_sel = ($urandom_range(0, 9) == 0) ? 5'd29 : 5'($urandom_range(0, 7));
      rd_sel  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #2;
      check_models($sformatf("rnd%0d", n));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
